// File: rtl/set_associative_cache.sv
// A-way set-associative, write-allocate, write-back cache with true-LRU replacement per set.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module set_associative_cache #(
    parameter int WIDTH = 32,
    parameter int C     = 32,
    parameter int B     = 4,
    parameter int A     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] address_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             wen_i,
    input  logic             ren_i,
    output logic             hit_o,
    output logic [WIDTH-1:0] data_o,
    output logic             evict_valid_o,
    output logic [WIDTH-1:0] evict_address_o,
    output logic [WIDTH-1:0] evict_data_o,
    output logic [31:0]      hit_count_o,
    output logic [31:0]      miss_count_o
);

    localparam int S      = C / (A * B);
    localparam int OFF_W  = $clog2(B);
    localparam int IDX_W  = $clog2(S);
    localparam int IDX_VW = (IDX_W > 0) ? IDX_W : 1;
    localparam int TAG_W  = WIDTH - OFF_W - IDX_W;
    localparam int AGE_W  = $clog2(A);

    logic             valid_q [S][A];
    logic             dirty_q [S][A];
    logic [AGE_W-1:0] age_q   [S][A];
    logic [TAG_W-1:0] tag_q   [S][A];
    logic [WIDTH-1:0] data_q  [S][A];

    logic [IDX_VW-1:0] idx;
    logic [TAG_W-1:0]  tag;
    logic              unused_offset;

    generate
        if (IDX_W > 0) begin : g_idx
            assign idx = address_i[OFF_W+IDX_W-1:OFF_W];
        end else begin : g_no_idx
            assign idx = '0;
        end
    endgenerate

    assign tag           = address_i[WIDTH-1:OFF_W+IDX_W];
    assign unused_offset = ^address_i[OFF_W-1:0];

    logic             is_write, is_read;
    logic             hit, inv_found;
    logic [AGE_W-1:0] hit_way, inv_way, lru_way, victim, touch_way, touch_age;
    logic             touch_en, evict;
    logic [WIDTH-1:0] evict_addr;

    // Write wins when both request lines are high.
    assign is_write = wen_i;
    assign is_read  = ren_i && !wen_i;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = 0; w < A; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (!valid_q[idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = AGE_W'(w);
            end
            if (valid_q[idx][w] && age_q[idx][w] == AGE_W'(A - 1)) begin
                lru_way = AGE_W'(w);
            end
        end
    end

    assign victim    = inv_found ? inv_way : lru_way;
    assign touch_way = (is_write && !hit) ? victim : hit_way;
    assign touch_en  = is_write || (is_read && hit);
    // An invalid way being filled behaves as if it were the oldest line.
    assign touch_age = valid_q[idx][touch_way] ? age_q[idx][touch_way] : AGE_W'(A - 1);
    assign evict     = is_write && !hit && valid_q[idx][victim] && dirty_q[idx][victim];
    assign evict_addr = (WIDTH'(tag_q[idx][victim]) << (OFF_W + IDX_W))
                      | (WIDTH'(idx) << OFF_W);

    // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < S; s++) begin
                for (int w = 0; w < A; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= '0;
                end
            end
        end else begin
            if (is_write) begin
                valid_q[idx][touch_way] <= 1'b1;
                dirty_q[idx][touch_way] <= 1'b1;
            end
            if (touch_en) begin
                for (int w = 0; w < A; w++) begin
                    if (AGE_W'(w) == touch_way) begin
                        age_q[idx][w] <= '0;
                    end else if (valid_q[idx][w] && age_q[idx][w] < touch_age) begin
                        age_q[idx][w] <= age_q[idx][w] + AGE_W'(1);
                    end
                end
            end
        end
    end

    // NOTE: tag and data arrays carry no reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (is_write) begin
            tag_q[idx][touch_way]  <= tag;
            data_q[idx][touch_way] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_o           <= 1'b0;
            data_o          <= '0;
            evict_valid_o   <= 1'b0;
            evict_address_o <= '0;
            evict_data_o    <= '0;
        end else begin
            hit_o           <= (is_write || is_read) && hit;
            data_o          <= (is_read && hit) ? data_q[idx][hit_way] : '0;
            evict_valid_o   <= evict;
            evict_address_o <= evict ? evict_addr : '0;
            evict_data_o    <= evict ? data_q[idx][victim] : '0;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (is_write || is_read) begin
            if (hit) begin
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`else
    assign hit_count_o  = '0;
    assign miss_count_o = '0;
`endif

endmodule

// File: doc/set_associative_cache.md
# set_associative_cache

Parametrised A-way set-associative, write-allocate, write-back cache with true-LRU replacement per set. It generalises the fully associative single-set cache: it supports S ≥ 1 sets and adds dirty-victim eviction reporting. It sits between a core-side load/store port and a backing memory model; evicted dirty lines are presented on a one-cycle eviction port.

## Interface
- WIDTH, 32, address and data width in bits
- C, 32, total capacity in bytes
- B, 4, line size in bytes; must equal WIDTH/8 (one word per line)
- A, 4, associativity (ways per set); power of 2, ≥ 2
- S, C/(A*B), derived set count; power of 2, ≥ 1
- Derived field widths: offset = lg(B); index = lg(S) (0 when S = 1); tag = WIDTH − offset − index
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- address_i  in  WIDTH  byte address; offset bits ignored
- data_i  in  WIDTH  write data
- wen_i  in  1  write request
- ren_i  in  1  read request
- hit_o  out  1  registered; 1 = previous request hit
- data_o  out  WIDTH  registered read data
- evict_valid_o  out  1  one-cycle pulse: dirty victim displaced
- evict_address_o  out  WIDTH  victim address {tag, index, offset = 0}
- evict_data_o  out  WIDTH  victim data
- hit_count_o  out  32  hit counter (see Configuration)
- miss_count_o  out  32  miss counter (see Configuration)

## Operation
- Per-line state: valid, dirty, tag, data, age[lg(A)-1:0]. Lookup uses index = address_i[offset+index-1:offset]; a hit is valid && tag match. At most one way can match.
- Read hit: data_o ← line data, hit_o ← 1, LRU touch.
- Read miss: hit_o ← 0, data_o ← 0. No allocation, LRU unchanged.
- Write hit: data ← data_i, dirty ← 1, hit_o ← 1, LRU touch.
- Write miss: hit_o ← 0. The victim is the lowest-index invalid way; otherwise the way with age A−1. The victim is filled with valid = 1, dirty = 1, new tag, data_i, and receives an LRU touch. If the victim was valid and dirty, the eviction port pulses with the old address and data.
- LRU touch of way w with old age a: ages of valid ways with age < a increment; age[w] ← 0. Filling an invalid way counts as a = A−1, so every other valid way increments. Ages in a set always remain a permutation over its valid ways.
- wen_i && ren_i: treated as a write. Write has priority.
- Idle cycle (no request): hit_o ← 0, data_o ← 0, evict_valid_o ← 0.
- Reset: all valid, dirty and age bits ← 0. Data and tag arrays are not reset. All outputs ← 0.

## Timing
- Requests are sampled on the rising edge. Responses are registered, so hit_o, data_o and the eviction port are valid for the full cycle after the sampling edge. Latency is 1 cycle.
- There is no stall and no handshake. A new request is accepted every cycle.
- A read in cycle n+1 to the address written in cycle n hits and returns the new data.
- rst_n assertion mid-stream clears state immediately and asynchronously. The first request is sampled on the first rising edge after deassertion.

## Configuration
- Macro: CACHE_STATS_EN.
- Defined: hit_count_o and miss_count_o increment once per sampled request, according to hit or miss. Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both ports are tied to 0 and no counter registers are built.

## Test plan
- A=4, S=1. Write 11/22/33/44/55 to 0x0400_0000/04/08/0C/10. Then read 0x00 → miss, data_o = 0. Read 0x04/08/0C/10 → hit, 22/33/44/55. Write of 55 pulses evict at 0x0400_0000, data 11.
- A=4, S=1, after reset. Write 111..444 to 0x00..0x0C. Read 0x00, 0x08 → hits. Write 555 @0x10, then 666 @0x14 → evicts 222 then 444. Reads: 0x04 and 0x0C miss; 0x00/08/10/14 hit.
- C=32, A=2, S=4. Writes to 0x00, 0x10, 0x20 (all index 0) → 0x20 evicts 0x00. Write to 0x04 (index 1) causes no eviction. Read 0x10 → hit.
- Write and read asserted together at 0x0400_0000, data 77 → treated as a write. The following read returns 77 with hit_o = 1.
- Assert rst_n low mid-sequence → all outputs 0 in the same cycle. After release, reading a previously written address → miss.
- With CACHE_STATS_EN defined, run the first scenario → hit_count_o = 4, miss_count_o = 6.
